// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the single-port RAM/HCI memory controller:
//   - RAM bus width and request-length bus width
//   - read/write encodings for the RAM write strobe
//   - controller FSM state and transaction-owner encodings
//   - default start of the I/O-mapped region
//   - norm_len(): maps a raw request length to the number of beats issued
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

  localparam int RAM_W = 8;
  localparam int LEN_W = 3;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } mc_state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSB = 1'b1
  } mc_owner_t;

  // Only 1, 2 and 4 byte accesses exist; anything else is issued as a word.
  function automatic logic [LEN_W-1:0] norm_len(input logic [LEN_W-1:0] len);
    case (len)
      3'd1:    norm_len = 3'd1;
      3'd2:    norm_len = 3'd2;
      default: norm_len = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_byte_assembler.sv
// -----------------------------------------------------------------------------
// mem_byte_assembler
// Beat counter plus little-endian read-data capture register.
//   clk, rst   : clock, asynchronous active-low reset (counter only)
//   i_en       : global enable; 0 holds everything
//   i_start    : new transaction, counter and data cleared
//   i_step     : advance the beat counter
//   i_cap      : capture i_din into byte lane (o_cnt - 1)
//   i_din      : RAM read byte
//   o_cnt      : current beat number
//   o_data     : assembled, zero-extended data
// -----------------------------------------------------------------------------
module mem_byte_assembler
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_start,
  input  logic              i_step,
  input  logic              i_cap,
  input  logic [RAM_W-1:0]  i_din,
  output logic [LEN_W-1:0]  o_cnt,
  output logic [DATA_W-1:0] o_data
);

  localparam int NBYTES = DATA_W / 8;

  logic [LEN_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        w_lane;

  // RAM data lags its address by one cycle, so the byte arriving now
  // belongs to the beat before the current counter value.
  assign w_lane = 2'(r_cnt - 3'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (i_start)     r_cnt <= '0;
      else if (i_step) r_cnt <= r_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_start) begin
        r_data <= '0;
      end else if (i_cap) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (w_lane == 2'(b)) r_data[b*8 +: 8] <= i_din;
        end
      end
    end
  end

  assign o_cnt  = r_cnt;
  assign o_data = r_data;

endmodule

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
// Single-port memory controller between the 8-bit RAM/HCI bus and two clients
// (instruction fetch and load/store buffer). Requests of 1/2/4 bytes are split
// into byte beats; read data is assembled little-endian and each request gets
// exactly one completion pulse (unless flushed).
//   clk, rst        : clock, asynchronous active-low reset
//   rdy             : global enable, 0 freezes all state and blocks writes
//   clear           : pipeline flush
//   io_buffer_full  : HCI output buffer full, stalls I/O-region writes
//   mem_din/dout/a/wr : RAM byte bus
//   IF_*            : fetch request (always 4 bytes) and completion
//   LSB_*           : load/store request and completion
// -----------------------------------------------------------------------------
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int                ADDR_W  = 32,
  parameter int                DATA_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(IO_BASE_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              io_buffer_full,
  input  logic [RAM_W-1:0]  mem_din,
  output logic [RAM_W-1:0]  mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              IF_enable,
  input  logic [ADDR_W-1:0] IF_addr,
  output logic              IF_data_valid,
  output logic [DATA_W-1:0] IF_data,
  input  logic              LSB_enable,
  input  logic              LSB_is_write,
  input  logic [ADDR_W-1:0] LSB_addr,
  input  logic [LEN_W-1:0]  LSB_data_len,
  input  logic [DATA_W-1:0] LSB_write_data,
  output logic              LSB_data_valid,
  output logic [DATA_W-1:0] LSB_data
);

  localparam int NBYTES = DATA_W / 8;

  mc_state_t         r_state;
  mc_owner_t         r_owner;
  logic              r_suppress;
  logic [ADDR_W-1:0] r_base;
  logic [LEN_W-1:0]  r_len;
  logic [DATA_W-1:0] r_wdata;

  mc_state_t         w_state_nx;
  logic              w_grant_lsb;
  logic              w_grant_if;
  logic              w_start;
  logic              w_step;
  logic              w_cap;
  logic              w_set_sup;
  logic [LEN_W-1:0]  w_cnt;
  logic [DATA_W-1:0] w_rdata;
  logic [ADDR_W-1:0] w_beat_addr;
  logic              w_more;
  logic              w_io_stall;
  logic              w_fire;
  logic [RAM_W-1:0]  w_wbyte;

  mem_byte_assembler #(
    .DATA_W (DATA_W)
  ) u_asm (
    .clk     (clk),
    .rst     (rst),
    .i_en    (rdy),
    .i_start (w_start),
    .i_step  (w_step),
    .i_cap   (w_cap),
    .i_din   (mem_din),
    .o_cnt   (w_cnt),
    .o_data  (w_rdata)
  );

  assign w_beat_addr = r_base + ADDR_W'(w_cnt);
  assign w_more      = (w_cnt < r_len);
  assign w_io_stall  = (w_beat_addr >= IO_BASE) && io_buffer_full;

  // Next-state and beat control
  always_comb begin
    w_state_nx  = r_state;
    w_grant_lsb = 1'b0;
    w_grant_if  = 1'b0;
    w_start     = 1'b0;
    w_step      = 1'b0;
    w_cap       = 1'b0;
    w_set_sup   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!clear) begin
          if (LSB_enable) begin
            w_grant_lsb = 1'b1;
            w_start     = 1'b1;
            w_state_nx  = LSB_is_write ? ST_WRITE : ST_READ;
          end else if (IF_enable) begin
            w_grant_if = 1'b1;
            w_start    = 1'b1;
            w_state_nx = ST_READ;
          end
        end
      end
      ST_READ: begin
        if (clear) begin
          w_state_nx = ST_IDLE;
        end else begin
          // Beat 0 has no returning byte yet; the cycle after the last
          // address beat only collects the final byte.
          w_cap = (w_cnt != 3'd0);
          if (w_more) w_step     = 1'b1;
          else        w_state_nx = ST_DONE;
        end
      end
      ST_WRITE: begin
        // A store already on the bus is committed: a flush only hides
        // its completion, the remaining beats still go out.
        if (clear) w_set_sup = 1'b1;
        if (!w_io_stall) begin
          w_step = 1'b1;
          if (w_cnt == r_len - 3'd1) w_state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // Control state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_owner    <= OWN_IF;
      r_suppress <= 1'b0;
    end else if (rdy) begin
      r_state <= w_state_nx;
      if (w_grant_lsb)     r_owner <= OWN_LSB;
      else if (w_grant_if) r_owner <= OWN_IF;
      if (w_start)        r_suppress <= 1'b0;
      else if (w_set_sup) r_suppress <= 1'b1;
    end
  end

  // Latched request
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (w_grant_lsb) begin
        r_base  <= LSB_addr;
        r_len   <= norm_len(LSB_data_len);
        r_wdata <= LSB_write_data;
      end else if (w_grant_if) begin
        r_base  <= IF_addr;
        r_len   <= 3'd4;
        r_wdata <= '0;
      end
    end
  end

  always_comb begin
    w_wbyte = '0;
    for (int b = 0; b < NBYTES; b++) begin
      if (w_cnt[1:0] == 2'(b)) w_wbyte = r_wdata[b*8 +: 8];
    end
  end

  // The address is only driven while a beat is live so that the idle bus
  // never touches I/O locations whose reads have side effects.
  assign mem_a    = ((r_state == ST_READ && w_more) || r_state == ST_WRITE) ? w_beat_addr : '0;
  assign mem_dout = (r_state == ST_WRITE) ? w_wbyte : '0;
  assign mem_wr   = (rdy && r_state == ST_WRITE && !w_io_stall) ? MEM_WRITE : MEM_READ;

  // Gating with rdy keeps the pulse to the single cycle in which DONE retires.
  assign w_fire         = rdy && (r_state == ST_DONE) && !clear && !r_suppress;
  assign IF_data_valid  = w_fire && (r_owner == OWN_IF);
  assign LSB_data_valid = w_fire && (r_owner == OWN_LSB);
  assign IF_data        = (r_state == ST_DONE && r_owner == OWN_IF)  ? w_rdata : '0;
  assign LSB_data       = (r_state == ST_DONE && r_owner == OWN_LSB) ? w_rdata : '0;

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Single-port memory controller between the 8-bit RAM/HCI bus and two clients: instruction fetch (IF) and the load/store buffer (LSB). It serialises 1/2/4-byte requests into byte beats, assembles little-endian read data, and returns one completion pulse per request. It arbitrates the single RAM port and handles flush (clear) and the HCI I/O-buffer-full stall.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, client data width
IO_BASE, 32'h30000, start of the I/O-mapped region that is subject to io_buffer_full

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
rdy  in  1  global enable; 0 freezes all state
clear  in  1  pipeline flush
io_buffer_full  in  1  HCI UART buffer full
mem_din  in  8  RAM read byte; valid the cycle after its address
mem_dout  out  8  RAM write byte
mem_a  out  ADDR_W  RAM byte address
mem_wr  out  1  1 = write, 0 = read
IF_enable  in  1  fetch request, level-held until served
IF_addr  in  ADDR_W  fetch address; always 4 bytes
IF_data_valid  out  1  one-cycle completion pulse to IF
IF_data  out  DATA_W  fetched word
LSB_enable  in  1  LSB request, level
LSB_is_write  in  1  1 = store
LSB_addr  in  ADDR_W  byte address
LSB_data_len  in  3  1, 2 or 4 bytes
LSB_write_data  in  DATA_W  store data, low bytes used
LSB_data_valid  out  1  one-cycle completion pulse to LSB
LSB_data  out  DATA_W  raw zero-extended load data; LSB performs sign extension

Behaviour:
- Reset (rst = 0, asynchronous): state IDLE, counter 0, mem_a = 0, mem_dout = 0, mem_wr = 0, IF_data_valid = 0, IF_data = 0, LSB_data_valid = 0, LSB_data = 0.
- rdy = 0: hold all registers; mem_wr forced to 0.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: if LSB_enable, latch the LSB request. Otherwise, if IF_enable, latch the IF request with length 4. LSB has priority. A client is never granted in the same cycle its completion pulse is high.
- READ, beat k = 0..len-1: drive mem_a = base + k, mem_wr = 0. Byte k is captured from mem_din one cycle later into bits [8k+7:8k].
  - After the last address beat, one extra cycle captures the final byte.
  - Go to DONE.
  - Latency from grant: len + 2 cycles to the valid pulse.
- WRITE, beat k: drive mem_a = base + k, mem_dout = write_data[8k+7:8k], mem_wr = 1. After len beats, go to DONE.
  - Stall for address >= IO_BASE: if the address is in the I/O region and io_buffer_full = 1, hold the beat with mem_wr = 0 and retry every cycle.
- DONE: pulse the owner's *_data_valid for exactly 1 cycle, drive *_data, then go to IDLE. The IDLE cycle that follows samples fresh client requests, because LSB_enable seen during DONE still reflects the old request.
- Unused upper bytes of *_data are 0.
- clear = 1 during an IDLE or READ transaction: abort immediately to IDLE, no valid pulse, mem_wr = 0.
- clear = 1 during a WRITE transaction: the store is already committed, so finish all remaining beats, suppress LSB_data_valid, then return to IDLE.
- clear = 1 in DONE: suppress the pulse.
- Address arithmetic is modulo 2^ADDR_W; wrap past 0xFFFFFFFF is not checked.
- Byte counter: 3 bits, compared against latched len.
- Illegal len (0, 3, >4): treated as 4.

Decomposition:
- Add to the shared cpu_define.v:
  - Read/Write encodings
  - LenBus width
  - mem_ctrl state encodings
  - IO_BASE constant
  - 8-bit RAM bus width
- Optional single sub-module mem_byte_assembler: shift-in register plus beat counter, instantiated once.

Test Plan:
- LW LSB read at 0x1000, RAM bytes 11,22,33,44 -> mem_a steps 0x1000..0x1003; LSB_data = 0x44332211 with a 1-cycle pulse 6 cycles after grant.
- IF_enable and LSB_enable asserted in the same cycle -> LSB served first; IF served next and gets its pulse after the LSB pulse plus one IDLE cycle.
- SB 0x000000AB to 0x30000 with io_buffer_full = 1 for 3 cycles -> mem_wr stays 0 for 3 cycles, then one write beat of 0xAB, then LSB_data_valid.
- SH 0xBEEF to 0x2002, clear after the first beat -> bytes EF then BE written to 0x2002/0x2003, no LSB_data_valid.
- IF read in progress, clear mid-beat -> IDLE next cycle, no IF_data_valid, mem_wr = 0.
- rst pulled low asynchronously mid-READ -> all outputs 0 immediately; rdy = 0 for 5 cycles mid-WRITE -> beat counter and mem_a held, no writes issued.
